fight_input_arbiter: RTL and testbench

- Sits between the PS/2 keyboard byte receiver and the two player movement modules.
- Parses the raw scancode byte stream (make, F0 break and E0 extended prefixes) into a held-key bitmap for both players.
- Once per frame, arbitrates each player's held keys down to one keycode and press pair.
- Holds that pair stable for the whole frame so player logic and animation counters see one consistent action per frame.

---
 rtl/fight_input_arbiter.sv | 113 +++++++++++
 tb/tb_fight_input_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fight_input_arbiter.sv
// fight_input_arbiter: PS/2 set-2 scancode parser plus per-frame two-player key arbitration.
// Optional INPUT_SOCD_NEUTRAL_EN: left+right held together cancel instead of last-pressed-wins.
module fight_input_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W = 18
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic [7:0] p1_keycode,
  output logic       p1_press,
  output logic [7:0] p2_keycode,
  output logic       p2_press,
  output logic [9:0] held
);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  // codes packed {atk, down, up, right, left}
  localparam logic [39:0] P1_CODES = {8'h2B, 8'h1B, 8'h1D, 8'h23, 8'h1C};
  localparam logic [39:0] P2_CODES = {8'h14, 8'h72, 8'h75, 8'h74, 8'h6B};
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0] held_q, held_d, mask, fresh;
  logic [1:0] lr_q, lr_d;
  logic [8:0] p1_q, p1_d, p2_q, p2_d;
  logic fd1_q, fd2_q, tick, mk, brk, ext;
  function automatic logic [9:0] key_mask(input logic [7:0] c, input logic e);
    logic [39:0] codes;
    codes = e ? P2_CODES : P1_CODES;
    key_mask = '0;
    for (int i = 0; i < 5; i++) key_mask[(e ? 5 : 0) + i] = (c == codes[i*8 +: 8]);
  endfunction
  function automatic logic [8:0] arb(input logic [4:0] h, input logic lr, input logic [39:0] codes);
    logic lr_hit, lr_sel;
`ifdef INPUT_SOCD_NEUTRAL_EN
    lr_hit = h[0] ^ h[1];
    lr_sel = h[1];
`else
    lr_hit = h[0] | h[1];
    lr_sel = (h[0] & h[1]) ? lr : h[1];
`endif
    arb = h[4] ? {1'b1, codes[39:32]} :
          h[2] ? {1'b1, codes[23:16]} :
          lr_hit ? {1'b1, lr_sel ? codes[15:8] : codes[7:0]} :
          h[3] ? {1'b1, codes[31:24]} : 9'h000;
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    mk = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          state_d = (scan_code == 8'hE0) ? GOT_E0 : (scan_code == 8'hF0) ? GOT_F0 : IDLE;
          mk = (scan_code != 8'hE0) && (scan_code != 8'hF0);
        end
        GOT_E0: begin
          ext = 1'b1;
          state_d = (scan_code == 8'hF0) ? GOT_E0F0 : (scan_code == 8'hE0) ? GOT_E0 : IDLE;
          mk = (scan_code != 8'hE0) && (scan_code != 8'hF0);
        end
        GOT_F0: begin
          brk = 1'b1;
          state_d = IDLE;
        end
        default: begin
          brk = 1'b1;
          ext = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      else cnt_d = cnt_q + 1'b1;
    end
    mask = key_mask(scan_code, ext);
    held_d = mk ? (held_q | mask) : brk ? (held_q & ~mask) : held_q;
    // only a genuinely new press moves recency; typematic repeats are filtered out
    fresh = mk ? (mask & ~held_q) : '0;
    lr_d[0] = fresh[0] ? 1'b0 : fresh[1] ? 1'b1 : lr_q[0];
    lr_d[1] = fresh[5] ? 1'b0 : fresh[6] ? 1'b1 : lr_q[1];
    tick = fd1_q & ~fd2_q;
    p1_d = tick ? arb(held_q[4:0], lr_q[0], P1_CODES) : p1_q;
    p2_d = tick ? arb(held_q[9:5], lr_q[1], P2_CODES) : p2_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      held_q <= '0;
      lr_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      fd1_q <= 1'b0;
      fd2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      held_q <= held_d;
      lr_q <= lr_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      fd1_q <= frame_clk;
      fd2_q <= fd1_q;
    end
  end
  assign {p1_press, p1_keycode} = p1_q;
  assign {p2_press, p2_keycode} = p2_q;
  assign held = held_q;
endmodule

// File: tb/tb_fight_input_arbiter.sv
// tb_fight_input_arbiter: directed plus random scancode streams checked against a key-set reference model.
module tb_fight_input_arbiter;
  localparam int TO = 50;
`ifdef INPUT_SOCD_NEUTRAL_EN
  localparam bit SOCD = 1'b1;
`else
  localparam bit SOCD = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00, p1_keycode, p2_keycode;
  logic p1_press, p2_press;
  logic [9:0] held;
  int checks = 0, errors = 0;
  logic [7:0] kc [10] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2B, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h14};
  logic [9:0] mh = '0;
  bit mlr [2] = '{1'b0, 1'b0};
  bit pe0 = 1'b0, pf0 = 1'b0;
  logic [8:0] mo1 = '0, mo2 = '0;

  fight_input_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .scan_valid(scan_valid), .scan_code(scan_code),
    .p1_keycode(p1_keycode), .p1_press(p1_press), .p2_keycode(p2_keycode), .p2_press(p2_press), .held(held));

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic key_event(input logic [7:0] b, input bit e, input bit is_make);
    for (int k = 0; k < 10; k++)
      if (kc[k] == b && (k >= 5) == e) begin
        if (is_make && !mh[k]) begin
          if (k % 5 == 0) mlr[k/5] = 1'b0;
          if (k % 5 == 1) mlr[k/5] = 1'b1;
        end
        mh[k] = is_make;
      end
  endtask

  task automatic mdl_byte(input logic [7:0] b);
    if (pf0) begin
      key_event(b, pe0, 1'b0);
      pe0 = 0;
      pf0 = 0;
    end else if (b == 8'hE0) pe0 = 1;
    else if (b == 8'hF0) pf0 = 1;
    else begin
      key_event(b, pe0, 1'b1);
      pe0 = 0;
    end
  endtask

  function automatic logic [8:0] marb(input int p);
    logic [4:0] h;
    h = mh[p*5 +: 5];
    if (h[4]) return {1'b1, kc[p*5+4]};
    if (h[2]) return {1'b1, kc[p*5+2]};
    if (h[0] && h[1]) begin
      if (!SOCD) return {1'b1, kc[p*5 + (mlr[p] ? 1 : 0)]};
    end else if (h[0]) return {1'b1, kc[p*5]};
    else if (h[1]) return {1'b1, kc[p*5+1]};
    if (h[3]) return {1'b1, kc[p*5+3]};
    return 9'h000;
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
    mh = '0;
    mlr = '{1'b0, 1'b0};
    pe0 = 0;
    pf0 = 0;
    mo1 = '0;
    mo2 = '0;
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code = b;
    cyc();
    scan_valid = 1'b0;
    mdl_byte(b);
    chk("held", held, mh);
  endtask

  task automatic check_outs();
    chk("p1_out", {1'b0, p1_press, p1_keycode}, {1'b0, mo1});
    chk("p2_out", {1'b0, p2_press, p2_keycode}, {1'b0, mo2});
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    cyc();
    mo1 = marb(0);
    mo2 = marb(1);
    cyc();
    frame_clk = 1'b0;
    cyc();
    check_outs();
  endtask

  // byte strobe lands on the same edge as the frame tick
  task automatic frame_with(input logic [7:0] b);
    frame_clk = 1'b1;
    cyc();
    mo1 = marb(0);
    mo2 = marb(1);
    scan_valid = 1'b1;
    scan_code = b;
    cyc();
    scan_valid = 1'b0;
    mdl_byte(b);
    frame_clk = 1'b0;
    cyc();
    check_outs();
    chk("held_sim", held, mh);
  endtask

  initial begin
    do_reset();
    chk("rst_held", held, 10'h000);
    chk("rst_p1", {1'b0, p1_press, p1_keycode}, 10'h000);
    chk("rst_p2", {1'b0, p2_press, p2_keycode}, 10'h000);
    send(8'h1C);
    chk("p1_left_held", held, 10'h001);
    frame();
    chk("p1_left_out", {1'b0, p1_press, p1_keycode}, 10'h11C);
    send(8'hF0); send(8'h1C);
    frame();
    chk("p1_release", {1'b0, p1_press, p1_keycode}, 10'h000);
    send(8'hE0); send(8'h74);
    chk("p2_right_held", held, 10'h040);
    frame();
    chk("p2_right_out", {1'b0, p2_press, p2_keycode}, 10'h174);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("p2_right_brk", held, 10'h000);
    send(8'h6B); send(8'hE0); send(8'h1C);
    chk("class_match", held, 10'h000);
    send(8'h1C); send(8'h23);
    frame();
    chk("lr_both", {1'b0, p1_press, p1_keycode}, SOCD ? 10'h000 : 10'h123);
    send(8'h1C);
    frame();
    chk("typematic", {1'b0, p1_press, p1_keycode}, SOCD ? 10'h000 : 10'h123);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
    send(8'h1C); send(8'h1D); send(8'h2B);
    frame();
    chk("prio_atk", {1'b0, p1_press, p1_keycode}, 10'h12B);
    send(8'hF0); send(8'h2B);
    frame();
    chk("prio_up", {1'b0, p1_press, p1_keycode}, 10'h11D);
    send(8'hF0); send(8'h1D);
    frame();
    chk("prio_left", {1'b0, p1_press, p1_keycode}, 10'h11C);
    send(8'hE0);
    repeat (TO + 3) cyc();
    pe0 = 0;
    send(8'h6B);
    chk("timeout_held", held, 10'h001);
    frame();
    chk("timeout_out", {1'b0, p2_press, p2_keycode}, 10'h000);
    send(8'hF0);
    frame_with(8'h1C);
    chk("sim_old", {1'b0, p1_press, p1_keycode}, 10'h11C);
    frame();
    chk("sim_new", {1'b0, p1_press, p1_keycode}, 10'h000);
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("rst_mid_seq", held, 10'h001);
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : (r < 9) ? kc[$urandom_range(0, 9)] : 8'($urandom_range(0, 255));
      send(b);
      repeat ($urandom_range(0, 2)) cyc();
      if (n % 7 == 6) frame();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
